result_drain: RTL and testbench

Output-side counterpart of the TPU `control_unit`. It watches the MMU feed sequence (`mmu_en`, `mmu_cycle`), captures the four 2×2 product results `c00`, `c01`, `c10` and `c11` in the cycle each becomes valid, and buffers them. It then streams them to the host over the 8-bit output bus, one byte per host read strobe. It sits between the systolic MMU outputs and the top-level `uo_out` pins, mirroring the byte-serial load path on the input side.

---
 rtl/result_drain_pkg.sv | 15 +
 rtl/result_drain.sv | 106 ++++++++++
 tb/tb_result_drain.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/result_drain_pkg.sv
// Shared constants for the result drain: the MMU feed cycle indices
// (common with control_unit) and the drain state encodings.
package result_drain_pkg;

  localparam logic [2:0] CYC_C00     = 3'd2;
  localparam logic [2:0] CYC_C01_C10 = 3'd3;
  localparam logic [2:0] CYC_C11     = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_DRAIN   = 2'b10
  } state_t;

endpackage

// File: rtl/result_drain.sv
// Captures the four 2x2 MMU results during the feed sequence and streams
// them to the host one byte per read strobe, MSB-first, c00..c11.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mmu_en,
  input  logic [2:0]       mmu_cycle,
  input  logic [ACC_W-1:0] c00,
  input  logic [ACC_W-1:0] c01,
  input  logic [ACC_W-1:0] c10,
  input  logic [ACC_W-1:0] c11,
  input  logic             read_en,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic [1:0]       state_out
);

  localparam int NBYTES = 4 * ACC_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t             state;
  logic [ACC_W-1:0]   buf0, buf1, buf2, buf3;
  logic [IDX_W-1:0]   byte_idx;
  logic [IDX_W-1:0]   next_idx;
  logic [4*ACC_W-1:0] all_bufs;
  logic [7:0]         next_byte;

  assign all_bufs  = {buf0, buf1, buf2, buf3};
  assign next_idx  = byte_idx + IDX_W'(1);
  assign state_out = state;

  // Byte k of the concatenation, counted from the MSB end
  always_comb begin
    next_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (next_idx == IDX_W'(k)) next_byte = all_bufs[8*(NBYTES-1-k) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      buf0       <= '0;
      buf1       <= '0;
      buf2       <= '0;
      buf3       <= '0;
      byte_idx   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mmu_en && mmu_cycle == CYC_C00) begin
            buf0    <= c00;
            overrun <= 1'b0;
            state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (!mmu_en) begin
            buf0  <= '0;
            buf1  <= '0;
            buf2  <= '0;
            buf3  <= '0;
            state <= S_IDLE;
          end else if (mmu_cycle == CYC_C01_C10) begin
            buf1 <= c01;
            buf2 <= c10;
          end else if (mmu_cycle == CYC_C11) begin
            // buf0 is already settled, so the first byte can be presented now
            buf3       <= c11;
            byte_idx   <= '0;
            data_out   <= buf0[ACC_W-1 -: 8];
            data_valid <= 1'b1;
            state      <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mmu_en && mmu_cycle == CYC_C00) overrun <= 1'b1;
          if (read_en && data_valid) begin
            if (byte_idx == IDX_W'(NBYTES-1)) begin
              data_valid <= 1'b0;
              data_out   <= '0;
              state      <= S_IDLE;
            end else begin
              byte_idx <= next_idx;
              data_out <= next_byte;
            end
          end
        end
        default: begin
          data_valid <= 1'b0;
          data_out   <= '0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed and randomized bench for result_drain, checked against a
// byte-queue reference model of the capture/drain behaviour.
module tb_result_drain;

  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             mmu_en;
  logic [2:0]       mmu_cycle;
  logic [ACC_W-1:0] c00, c01, c10, c11;
  logic             read_en;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             overrun;
  logic [1:0]       state_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [ACC_W-1:0] cap [4];
  logic [7:0]       q[$];
  bit               capturing;
  bit               ovr_m;

  always #5 clk = ~clk;

  result_drain #(.ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mmu_en     (mmu_en),
    .mmu_cycle  (mmu_cycle),
    .c00        (c00),
    .c01        (c01),
    .c10        (c10),
    .c11        (c11),
    .read_en    (read_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun),
    .state_out  (state_out)
  );

  // Reference: pending bytes live in a queue; draining is simply popping it
  task automatic modelStep();
    if (rst) begin
      q.delete();
      capturing = 0;
      ovr_m     = 0;
      for (int i = 0; i < 4; i++) cap[i] = '0;
    end else if (q.size() != 0) begin
      if (mmu_en && mmu_cycle == 3'd2) ovr_m = 1;
      if (read_en) void'(q.pop_front());
    end else if (capturing) begin
      if (!mmu_en) begin
        capturing = 0;
        for (int i = 0; i < 4; i++) cap[i] = '0;
      end else if (mmu_cycle == 3'd3) begin
        cap[1] = c01;
        cap[2] = c10;
      end else if (mmu_cycle == 3'd4) begin
        cap[3]    = c11;
        capturing = 0;
        for (int i = 0; i < 4; i++)
          for (int b = ACC_W/8 - 1; b >= 0; b--) q.push_back(cap[i][8*b +: 8]);
      end
    end else if (mmu_en && mmu_cycle == 3'd2) begin
      cap[0]    = c00;
      capturing = 1;
      ovr_m     = 0;
    end
  endtask

  task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [1:0] exp_state;
    exp_state = (q.size() != 0) ? 2'b10 : (capturing ? 2'b01 : 2'b00);
    check1("state_out", {6'b0, state_out}, {6'b0, exp_state});
    check1("data_valid", {7'b0, data_valid}, {7'b0, q.size() != 0});
    check1("data_out", data_out, (q.size() != 0) ? q[0] : 8'h00);
    check1("overrun", {7'b0, overrun}, {7'b0, ovr_m});
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] cyc,
                               input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                               input logic [ACC_W-1:0] c, input logic [ACC_W-1:0] d,
                               input logic rd, input logic rs);
    mmu_en    = en;
    mmu_cycle = cyc;
    c00       = a;
    c01       = b;
    c10       = c;
    c11       = d;
    read_en   = rd;
    rst       = rs;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idleStep(input logic rd);
    applyStimulus(1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), rd, 1'b0);
  endtask

  task automatic feed(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                      input logic [ACC_W-1:0] c, input logic [ACC_W-1:0] d);
    for (int k = 0; k <= 4; k++) applyStimulus(1'b1, 3'(k), a, b, c, d, 1'b0, 1'b0);
  endtask

  task automatic drainAll(input int period);
    for (int n = 0; n < 200 && q.size() != 0; n++) idleStep(((n % period) == period - 1));
    check1("drain_bound", {7'b0, data_valid}, 8'h00);
  endtask

  initial begin
    logic [ACC_W-1:0] r0, r1, r2, r3;
    logic [2:0] noise_cyc [3];
    noise_cyc[0] = 3'd0;
    noise_cyc[1] = 3'd1;
    noise_cyc[2] = 3'd5;

    // Reset
    applyStimulus(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 1'b1);

    // Idle noise: reads and non-start feed cycles do nothing
    for (int i = 0; i < 12; i++)
      applyStimulus(1'($urandom), noise_cyc[$urandom_range(0, 2)], 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

    // Full pass with read_en held high
    feed(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    drainAll(1);
    idleStep(1'b1);

    // Stalled reads, one strobe every third cycle
    feed(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    drainAll(3);

    // Abort after cycle 3, then a feed skipping cycle 3 exposes cleared buffers
    applyStimulus(1'b1, 3'd2, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd3, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd4, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b1, 1'b0);
    idleStep(1'b1);
    applyStimulus(1'b1, 3'd2, 16'h1234, 16'h1111, 16'h2222, 16'h5678, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd4, 16'h1234, 16'h1111, 16'h2222, 16'h5678, 1'b0, 1'b0);
    drainAll(1);

    // Overrun: a second sequence starts after two bytes are drained
    feed(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    idleStep(1'b1);
    idleStep(1'b1);
    for (int k = 2; k <= 4; k++)
      applyStimulus(1'b1, 3'(k), 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    drainAll(1);
    feed(16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011);
    drainAll(2);

    // Reset mid-drain, then a full pass
    feed(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    for (int i = 0; i < 4; i++) idleStep(1'b1);
    applyStimulus(1'b0, 3'd0, '0, '0, '0, '0, 1'b1, 1'b1);
    feed(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    drainAll(1);

    // Randomized passes with random strobes and feed noise during the drain
    for (int p = 0; p < 8; p++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      r2 = 16'($urandom);
      r3 = 16'($urandom);
      feed(r0, r1, r2, r3);
      for (int n = 0; n < 60 && q.size() != 0; n++)
        applyStimulus(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 5)),
                      16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      1'($urandom), 1'b0);
      idleStep(1'b0);
      drainAll(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
